// File: rtl/de_port_arbiter.sv
// Two-master arbiter for the shared drawing-engine memory port; a grant is held for the whole burst.
// Define DE_ARB_ROUND_ROBIN_EN to alternate on simultaneous requests (default: m0 always wins).
module de_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  output logic        m0_ack,
  output logic        m1_ack,
  input  logic [17:0] m0_addr,
  input  logic [17:0] m1_addr,
  input  logic [3:0]  m0_nbyte,
  input  logic [3:0]  m1_nbyte,
  input  logic        m0_rnw,
  input  logic        m1_rnw,
  input  logic [31:0] m0_w_data,
  input  logic [31:0] m1_w_data,
  output logic [31:0] m0_r_data,
  output logic [31:0] m1_r_data,
  output logic        de_req,
  input  logic        de_ack,
  output logic [17:0] de_addr,
  output logic [3:0]  de_nbyte,
  output logic        de_rnw,
  output logic [31:0] de_w_data,
  input  logic [31:0] de_r_data,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_served;
  logic        last_served_nxt;
  logic [1:0]  grant_nxt;

  // Next-state: arbitrate only from IDLE, hold the owner until it drops req
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    grant_nxt       = 2'b00;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
`ifdef DE_ARB_ROUND_ROBIN_EN
          state_nxt = last_served ? GRANT0 : GRANT1;
`else
          state_nxt = GRANT0;
`endif
        end else if (m0_req) begin
          state_nxt = GRANT0;
        end else if (m1_req) begin
          state_nxt = GRANT1;
        end
        if (state_nxt == GRANT0) last_served_nxt = 1'b0;
        if (state_nxt == GRANT1) last_served_nxt = 1'b1;
      end
      GRANT0:  if (!m0_req) state_nxt = IDLE;
      GRANT1:  if (!m1_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      GRANT0:  grant_nxt = 2'b01;
      GRANT1:  grant_nxt = 2'b10;
      default: grant_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
      grant       <= 2'b00;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      grant       <= grant_nxt;
      busy        <= |grant_nxt;
    end
  end

  // Port steering keys off the registered grant so reset drops it immediately
  always_comb begin
    de_req    = 1'b0;
    de_addr   = 18'd0;
    de_nbyte  = 4'b1111;
    de_rnw    = 1'b1;
    de_w_data = 32'd0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_r_data = 32'd0;
    m1_r_data = 32'd0;
    if (grant[0]) begin
      de_req    = m0_req;
      de_addr   = m0_addr;
      de_nbyte  = m0_nbyte;
      de_rnw    = m0_rnw;
      de_w_data = m0_w_data;
      m0_ack    = de_ack;
      m0_r_data = de_r_data;
    end else if (grant[1]) begin
      de_req    = m1_req;
      de_addr   = m1_addr;
      de_nbyte  = m1_nbyte;
      de_rnw    = m1_rnw;
      de_w_data = m1_w_data;
      m1_ack    = de_ack;
      m1_r_data = de_r_data;
    end
  end

endmodule

// File: tb/tb_de_port_arbiter.sv
// Randomized and directed bench for de_port_arbiter against an ownership-level reference model.
// Build with or without DE_ARB_ROUND_ROBIN_EN to match the DUT configuration.
module tb_de_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req   [2];
  logic [17:0] addr  [2];
  logic [3:0]  nbyte [2];
  logic        rnw   [2];
  logic [31:0] wdata [2];
  logic        de_ack;
  logic [31:0] de_r_data;

  logic        m0_ack, m1_ack, de_req, de_rnw, busy;
  logic [31:0] m0_r_data, m1_r_data, de_w_data;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [1:0]  grant;

  int checks;
  int failures;

  // Reference model: who owns the port (-1 = nobody) and who was served last
  int owner;
  int last;

  de_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (req[0]),
    .m1_req    (req[1]),
    .m0_ack    (m0_ack),
    .m1_ack    (m1_ack),
    .m0_addr   (addr[0]),
    .m1_addr   (addr[1]),
    .m0_nbyte  (nbyte[0]),
    .m1_nbyte  (nbyte[1]),
    .m0_rnw    (rnw[0]),
    .m1_rnw    (rnw[1]),
    .m0_w_data (wdata[0]),
    .m1_w_data (wdata[1]),
    .m0_r_data (m0_r_data),
    .m1_r_data (m1_r_data),
    .de_req    (de_req),
    .de_ack    (de_ack),
    .de_addr   (de_addr),
    .de_nbyte  (de_nbyte),
    .de_rnw    (de_rnw),
    .de_w_data (de_w_data),
    .de_r_data (de_r_data),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1;
  endtask

  task automatic model_advance();
    if (owner < 0) begin
      if (req[0] && req[1]) begin
`ifdef DE_ARB_ROUND_ROBIN_EN
        owner = 1 - last;
`else
        owner = 0;
`endif
      end else if (req[0]) owner = 0;
      else if (req[1]) owner = 1;
      if (owner >= 0) last = owner;
    end else if (!req[owner]) begin
      owner = -1;
    end
  endtask

  task automatic check_all();
    logic [1:0]  e_grant;
    logic        e_req, e_rnw;
    logic [17:0] e_addr;
    logic [3:0]  e_nbyte;
    logic [31:0] e_wd;
    e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    e_req   = (owner >= 0) ? req[owner]   : 1'b0;
    e_addr  = (owner >= 0) ? addr[owner]  : 18'd0;
    e_nbyte = (owner >= 0) ? nbyte[owner] : 4'b1111;
    e_rnw   = (owner >= 0) ? rnw[owner]   : 1'b1;
    e_wd    = (owner >= 0) ? wdata[owner] : 32'd0;
    check("grant",     64'(grant),     64'(e_grant));
    check("busy",      64'(busy),      64'(owner >= 0));
    check("de_req",    64'(de_req),    64'(e_req));
    check("de_addr",   64'(de_addr),   64'(e_addr));
    check("de_nbyte",  64'(de_nbyte),  64'(e_nbyte));
    check("de_rnw",    64'(de_rnw),    64'(e_rnw));
    check("de_w_data", 64'(de_w_data), 64'(e_wd));
    check("m0_ack",    64'(m0_ack),    64'((owner == 0) && de_ack));
    check("m1_ack",    64'(m1_ack),    64'((owner == 1) && de_ack));
    check("m0_r_data", 64'(m0_r_data), 64'((owner == 0) ? de_r_data : 32'd0));
    check("m1_r_data", 64'(m1_r_data), 64'((owner == 1) ? de_r_data : 32'd0));
  endtask

  // Advance one clock: model samples inputs at the edge, outputs checked 1ns later
  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
    check_all();
  endtask

  // Re-check combinational paths after an input change between edges
  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_de_req", 64'(de_req), 64'd0);
    check("rst_grant",  64'(grant),  64'd0);
    check("rst_nbyte",  64'(de_nbyte), 64'hf);
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = 18'd0; nbyte[i] = 4'b1111; rnw[i] = 1'b1; wdata[i] = 32'd0;
    end
    de_ack = 1'b0;
    de_r_data = 32'd0;

    // Reset state
    #12;
    check_all();
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // m0 write access, one-cycle grant latency, ack routing
    req[0] = 1'b1; addr[0] = 18'h00100; nbyte[0] = 4'b1110; rnw[0] = 1'b0; wdata[0] = 32'h12345678;
    settle();
    check("latency_grant_still_idle", 64'(grant), 64'd0);
    tick();
    check("m0_grant", 64'(grant), 64'b01);
    check("m0_de_addr", 64'(de_addr), 64'h00100);
    de_ack = 1'b1; settle();
    check("m0_ack_follows", 64'(m0_ack), 64'd1);
    de_ack = 1'b0; settle();

    // m0 holds the port across three transfers while m1 waits
    req[1] = 1'b1; addr[1] = 18'h2abcd; nbyte[1] = 4'b0000; rnw[1] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      de_ack = 1'b1; de_r_data = 32'hA0000000 + 32'(p);
      tick();
      check("m1_waits_ack", 64'(m1_ack), 64'd0);
      de_ack = 1'b0;
      tick();
    end
    req[0] = 1'b0;
    tick();
    check("idle_gap", 64'(grant), 64'b00);
    tick();
    check("m1_after_gap", 64'(grant), 64'b10);
    req[1] = 1'b0;
    tick();
    tick();

    // de_ack in IDLE must not reach any master
    de_ack = 1'b1; de_r_data = 32'hDEADBEEF;
    settle();
    check("idle_m0_ack", 64'(m0_ack), 64'd0);
    check("idle_m1_ack", 64'(m1_ack), 64'd0);
    check("idle_m0_rd",  64'(m0_r_data), 64'd0);
    check("idle_m1_rd",  64'(m1_r_data), 64'd0);
    tick();
    de_ack = 1'b0;

    // Simultaneous requests from reset, then again after both release
    @(posedge clk); #2;
    pulse_reset();
    req[0] = 1'b1; req[1] = 1'b1;
    tick();
    check("both_first", 64'(grant), 64'b01);
    req[0] = 1'b0; req[1] = 1'b0;
    tick();
    tick();
    req[0] = 1'b1; req[1] = 1'b1;
    tick();
`ifdef DE_ARB_ROUND_ROBIN_EN
    check("both_second", 64'(grant), 64'b10);
`else
    check("both_second", 64'(grant), 64'b01);
`endif
    req[0] = 1'b0; req[1] = 1'b0;
    tick();
    tick();

    // Reset mid-burst in GRANT1, then both requesting after release
    req[1] = 1'b1;
    tick();
    check("g1_before_reset", 64'(grant), 64'b10);
    de_ack = 1'b1;
    #2;
    pulse_reset();
    de_ack = 1'b0;
    req[0] = 1'b1;
    tick();
    check("after_reset_both", 64'(grant), 64'b01);

    // Randomized traffic with occasional asynchronous reset
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
        addr[i]  = 18'($urandom);
        nbyte[i] = 4'($urandom);
        rnw[i]   = 1'($urandom);
        wdata[i] = $urandom;
      end
      de_ack    = 1'($urandom);
      de_r_data = $urandom;
      settle();
      if ($urandom_range(49) == 0) pulse_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/de_port_arbiter.md
DE_PORT_ARBITER -- requirements
Module: de_port_arbiter

Interface
REQ-001 The block SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have ports: m0_req / m1_req  input  1 each  requester holds high for the whole access burst.
REQ-004 The block SHALL have ports: m0_ack / m1_ack  output  1 each  per-transfer acknowledge routed from de_ack.
REQ-005 The block SHALL have ports: m0_addr / m1_addr  input  18 each  word address.
REQ-006 The block SHALL have ports: m0_nbyte / m1_nbyte  input  4 each  active-low byte enables.
REQ-007 The block SHALL have ports: m0_rnw / m1_rnw  input  1 each  1 = read, 0 = write.
REQ-008 The block SHALL have ports: m0_w_data / m1_w_data  input  32 each  write data.
REQ-009 The block SHALL have ports: m0_r_data / m1_r_data  output  32 each  read data.
REQ-010 The block SHALL have port: de_req  output  1  request to the shared drawing-engine memory port.
REQ-011 The block SHALL have ports: de_ack input 1; de_addr output 18; de_nbyte output 4; de_rnw output 1; de_w_data output 32; de_r_data input 32 (shared port).
REQ-012 The block SHALL have ports: grant  output  2  one-hot owner, bit0 = m0, bit1 = m1, 00 = none; busy  output  1  high when grant != 00.

Function
REQ-013 The block SHALL implement states IDLE, GRANT0 and GRANT1, with grant registered and decoded from the state.
REQ-014 In IDLE with any mN_req high, the block SHALL enter GRANTn at the next edge (one-cycle arbitration latency); with no request it SHALL remain in IDLE.
REQ-015 In GRANTn the block SHALL drive de_req = mN_req and de_addr/de_nbyte/de_rnw/de_w_data from master n, combinationally.
REQ-016 In GRANTn the block SHALL drive mN_ack = de_ack and mN_r_data = de_r_data; the non-granted master SHALL see ack 0 and r_data 0.
REQ-017 The grant SHALL persist while mN_req stays high, across any number of de_ack transfers; there is no preemption.
REQ-018 When mN_req is low at an edge in GRANTn, the block SHALL return to IDLE, giving one idle cycle before any new grant.
REQ-019 In IDLE, outputs SHALL be: de_req 0, de_addr 0, de_nbyte 4'b1111 (no lanes), de_rnw 1, de_w_data 0, both acks 0, both r_data 0.
REQ-020 de_ack arriving in IDLE SHALL be ignored and SHALL NOT be routed to any master.
REQ-021 A requester that raises req while the other holds the grant SHALL wait, with ack held 0, until the block returns to IDLE.
REQ-022 The block SHALL keep a 1-bit last-served register, updated to n on every entry to GRANTn.

Reset
REQ-023 While rst_n = 0, the block SHALL immediately force state IDLE, last-served = 1 (so m0 wins first), grant 00, busy 0 and all REQ-019 output values.
REQ-024 Reset asserted mid-burst SHALL drop de_req asynchronously; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-025 The block SHALL provide macro DE_ARB_ROUND_ROBIN_EN to select the arbitration policy on simultaneous requests in IDLE.
REQ-026 With DE_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the master that is not last-served.
REQ-027 Without DE_ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always be granted to m0; last-served SHALL still update but SHALL have no effect.

Verification
REQ-028 The bench SHALL cover: reset release, m0_req=1, addr 18'h00100, nbyte 4'b1110, rnw 0 -> grant=01 one cycle later, de_req=1, de_addr=18'h00100, m0_ack follows de_ack.
REQ-029 The bench SHALL cover: m0 holds req for 3 de_ack pulses while m1_req=1 -> m1_ack stays 0 throughout; m0 drops req -> IDLE for 1 cycle -> grant=10.
REQ-030 The bench SHALL cover: m0_req and m1_req rise together from reset -> grant=01; after release both re-request -> grant=10 with the macro defined, 01 without.
REQ-031 The bench SHALL cover: de_ack=1 with de_r_data=32'hDEADBEEF in IDLE -> m0_ack=m1_ack=0 and r_data=0 on both masters.
REQ-032 The bench SHALL cover: rst_n low mid-burst in GRANT1 -> de_req=0, grant=00, de_nbyte=4'b1111 before the next clk edge; after release with both req high -> grant=01.
